// File: rtl/sdram_rd_burst_ctrl_pkg.sv
// sdram_rd_burst_ctrl_pkg: SDRAM command type and {CS_n,RAS_n,CAS_n,WE_n} encodings shared by the read engine
package sdram_rd_burst_ctrl_pkg;
  typedef logic [3:0] sdram_cmd_t;
  localparam sdram_cmd_t CMD_NOP  = 4'b0111;
  localparam sdram_cmd_t CMD_ACT  = 4'b0011;
  localparam sdram_cmd_t CMD_READ = 4'b0101;
  localparam sdram_cmd_t CMD_BST  = 4'b0110;
  localparam sdram_cmd_t CMD_PRE  = 4'b0010;
endpackage

// File: rtl/sdram_rd_lat_pipe.sv
// sdram_rd_lat_pipe: CAS-latency shift of the word-issued flag plus output data register (in: clk, rst, word_issued, din; out: valid, dout)
module sdram_rd_lat_pipe #(
  parameter int CAS_LAT = 3,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              word_issued,
  input  logic [DATA_W-1:0] din,
  output logic              valid,
  output logic [DATA_W-1:0] dout
);
  logic [CAS_LAT-1:0] pipe_q, pipe_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  always_comb begin
    pipe_d  = CAS_LAT'({pipe_q, word_issued});
    valid_d = pipe_q[CAS_LAT-1];
    dout_d  = pipe_q[CAS_LAT-1] ? din : dout_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q  <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      pipe_q  <= pipe_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end
  assign valid = valid_q;
  assign dout  = dout_q;
endmodule

// File: rtl/sdram_rd_burst_ctrl.sv
// sdram_rd_burst_ctrl: full-page-burst SDRAM read engine ACT->READ->BST->PRE (in: rd_en/rd_addr/rd_burst_len/rd_abort/rd_sdram_data; out: rd_ack/rd_end/rd_data_valid/rd_data_out/rd_words_done/rd_sdram_cmd/addr/bank)
module sdram_rd_burst_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ROW_W   = 12,
  parameter int COL_W   = 9,
  parameter int BANK_W  = 2,
  parameter int LEN_W   = 10,
  parameter int CAS_LAT = 3,
  parameter int T_RCD   = 2,
  parameter int T_RP    = 2,
  localparam int ADDR_W = BANK_W + ROW_W + COL_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic              rd_abort,
  input  logic [DATA_W-1:0] rd_sdram_data,
  output logic              rd_ack,
  output logic              rd_end,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data_out,
  output logic [LEN_W-1:0]  rd_words_done,
  output logic [3:0]        rd_sdram_cmd,
  output logic [ROW_W-1:0]  rd_sdram_addr,
  output logic [BANK_W-1:0] rd_sdram_bank
);
  import sdram_rd_burst_ctrl_pkg::*;
  localparam int WAIT_W = 8;
  localparam logic [LEN_W-1:0] PAGE = LEN_W'(2 ** COL_W);
  localparam logic [ROW_W-1:0] A10 = ROW_W'(1 << 10);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ACT   = 4'd1;
  localparam logic [3:0] S_TRCD  = 4'd2;
  localparam logic [3:0] S_RD    = 4'd3;
  localparam logic [3:0] S_BURST = 4'd4;
  localparam logic [3:0] S_BST   = 4'd5;
  localparam logic [3:0] S_DRAIN = 4'd6;
  localparam logic [3:0] S_PRE   = 4'd7;
  localparam logic [3:0] S_TRP   = 4'd8;
  localparam logic [3:0] S_END   = 4'd9;
  logic [3:0]        state_q, state_d;
  logic [BANK_W-1:0] bank_q, bank_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_burst_q, cnt_burst_d;
  logic [WAIT_W-1:0] cnt_wait_q, cnt_wait_d;
  logic [LEN_W-1:0]  words_done_q, words_done_d;
  logic              word_issued;
  sdram_cmd_t        cmd;
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    row_d        = row_q;
    col_d        = col_q;
    len_d        = len_q;
    cnt_burst_d  = cnt_burst_q;
    cnt_wait_d   = cnt_wait_q;
    unique case (state_q)
      S_IDLE: if (rd_en && init_end && rd_burst_len != '0) begin
        state_d               = S_ACT;
        {bank_d, row_d, col_d} = rd_addr;
        len_d                 = rd_burst_len > PAGE ? PAGE : rd_burst_len;
        cnt_burst_d           = '0;
      end
      S_ACT: begin
        state_d    = T_RCD == 1 ? S_RD : S_TRCD;
        cnt_wait_d = WAIT_W'(T_RCD - 2);
      end
      S_TRCD: begin
        state_d    = cnt_wait_q == '0 ? S_RD : S_TRCD;
        cnt_wait_d = cnt_wait_q - WAIT_W'(1);
      end
      S_RD, S_BURST: begin
        cnt_burst_d = cnt_burst_q + LEN_W'(1);
        state_d     = (cnt_burst_d == len_q || (state_q == S_BURST && rd_abort)) ? S_BST : S_BURST;
      end
      S_BST: begin
        state_d    = S_DRAIN;
        cnt_wait_d = WAIT_W'(CAS_LAT);
      end
      S_DRAIN: begin
        state_d    = cnt_wait_q == '0 ? S_PRE : S_DRAIN;
        cnt_wait_d = cnt_wait_q - WAIT_W'(1);
      end
      S_PRE: begin
        state_d    = T_RP == 1 ? S_END : S_TRP;
        cnt_wait_d = WAIT_W'(T_RP - 2);
      end
      S_TRP: begin
        state_d    = cnt_wait_q == '0 ? S_END : S_TRP;
        cnt_wait_d = cnt_wait_q - WAIT_W'(1);
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    words_done_d = state_d == S_END ? cnt_burst_q : words_done_q;
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      bank_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      len_q        <= '0;
      cnt_burst_q  <= '0;
      cnt_wait_q   <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      col_q        <= col_d;
      len_q        <= len_d;
      cnt_burst_q  <= cnt_burst_d;
      cnt_wait_q   <= cnt_wait_d;
      words_done_q <= words_done_d;
    end
  end
  assign word_issued   = state_q == S_RD || state_q == S_BURST;
  assign cmd           = state_q == S_ACT ? CMD_ACT :
                         state_q == S_RD  ? CMD_READ :
                         state_q == S_BST ? CMD_BST :
                         state_q == S_PRE ? CMD_PRE : CMD_NOP;
  assign rd_sdram_cmd  = cmd;
  assign rd_sdram_addr = cmd == CMD_ACT  ? row_q :
                         cmd == CMD_READ ? ROW_W'(col_q) & ~A10 :
                         cmd == CMD_PRE  ? '0 : '1;
  assign rd_sdram_bank = cmd == CMD_NOP || cmd == CMD_BST ? '1 : bank_q;
  assign rd_ack        = state_q != S_IDLE;
  assign rd_end        = state_q == S_END;
  assign rd_words_done = words_done_q;
  sdram_rd_lat_pipe #(.CAS_LAT(CAS_LAT), .DATA_W(DATA_W)) u_pipe (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .word_issued (word_issued),
    .din         (rd_sdram_data),
    .valid       (rd_data_valid),
    .dout        (rd_data_out)
  );
endmodule

// File: tb/tb_sdram_rd_burst_ctrl.sv
// tb_sdram_rd_burst_ctrl: table-driven scoreboard bench running CL3 and CL2 engines side by side
module tb_sdram_rd_burst_ctrl;
  import sdram_rd_burst_ctrl_pkg::*;
  localparam int T_RCD = 2;
  localparam int T_RP  = 2;
  typedef struct {
    logic        init_end;
    int          len;
    logic [22:0] addr;
    int          abort_k;
    int          exp_words;
  } vec_t;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        init_end = 1'b1;
  logic        rd_en = 1'b0;
  logic        rd_abort = 1'b0;
  logic [22:0] rd_addr = '0;
  logic [9:0]  rd_burst_len = '0;
  logic [15:0] rd_sdram_data = '0;
  logic        o_ack [2];
  logic        o_end [2];
  logic        o_valid [2];
  logic [15:0] o_data [2];
  logic [9:0]  o_done [2];
  logic [3:0]  o_cmd [2];
  logic [11:0] o_addr [2];
  logic [1:0]  o_bank [2];
  logic [15:0] sb0 [$];
  logic [15:0] sb1 [$];
  logic [15:0] last [2];
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        tbl [11];
  always #5 sys_clk = ~sys_clk;
  sdram_rd_burst_ctrl #(.CAS_LAT(3)) u_cl3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_abort(rd_abort), .rd_sdram_data(rd_sdram_data),
    .rd_ack(o_ack[0]), .rd_end(o_end[0]), .rd_data_valid(o_valid[0]), .rd_data_out(o_data[0]),
    .rd_words_done(o_done[0]), .rd_sdram_cmd(o_cmd[0]), .rd_sdram_addr(o_addr[0]), .rd_sdram_bank(o_bank[0])
  );
  sdram_rd_burst_ctrl #(.CAS_LAT(2)) u_cl2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_end(init_end), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_burst_len(rd_burst_len), .rd_abort(rd_abort), .rd_sdram_data(rd_sdram_data),
    .rd_ack(o_ack[1]), .rd_end(o_end[1]), .rd_data_valid(o_valid[1]), .rd_data_out(o_data[1]),
    .rd_words_done(o_done[1]), .rd_sdram_cmd(o_cmd[1]), .rd_sdram_addr(o_addr[1]), .rd_sdram_bank(o_bank[1])
  );
  function automatic logic [15:0] dq_of(input int t, input int id);
    return 16'(t * 40503 + id * 977 + 1);
  endfunction
  task automatic chk(input string nm, input int d, input int t, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0d: got %0h want %0h", nm, d, t, act, exp);
    end
  endtask
  task automatic check_reset(input string nm);
    for (int d = 0; d < 2; d++) begin
      chk({nm, "_cmd"}, d, 0, o_cmd[d], CMD_NOP);
      chk({nm, "_addr"}, d, 0, o_addr[d], 12'hfff);
      chk({nm, "_bank"}, d, 0, o_bank[d], 2'b11);
      chk({nm, "_ack"}, d, 0, o_ack[d], 0);
      chk({nm, "_end"}, d, 0, o_end[d], 0);
      chk({nm, "_valid"}, d, 0, o_valid[d], 0);
      chk({nm, "_data"}, d, 0, o_data[d], 0);
      chk({nm, "_done"}, d, 0, o_done[d], 0);
    end
  endtask
  task automatic check_cycle(input int d, input int t, input vec_t v);
    int cl, n, tb, tp, te;
    logic busy;
    logic [3:0] ec;
    logic [15:0] e;
    cl = d == 0 ? 3 : 2;
    n = v.exp_words;
    busy = n != 0;
    tb = T_RCD + n;
    tp = tb + cl + 2;
    te = tp + T_RP;
    ec = !busy ? CMD_NOP : t == 0 ? CMD_ACT : t == T_RCD ? CMD_READ : t == tb ? CMD_BST : t == tp ? CMD_PRE : CMD_NOP;
    chk("cmd", d, t, o_cmd[d], ec);
    if (ec == CMD_PRE) chk("pre_a10", d, t, o_addr[d][10], 0);
    else chk("addr", d, t, o_addr[d], ec == CMD_ACT ? v.addr[20:9] : ec == CMD_READ ? 12'(v.addr[8:0]) : 12'hfff);
    if (ec != CMD_BST) chk("bank", d, t, o_bank[d], ec == CMD_NOP ? 2'b11 : v.addr[22:21]);
    chk("ack", d, t, o_ack[d], busy && t <= te);
    chk("end", d, t, o_end[d], busy && t == te);
    if (busy && t == te) chk("words_done", d, t, o_done[d], n);
    chk("valid", d, t, o_valid[d], busy && t >= T_RCD + cl + 1 && t <= T_RCD + cl + n);
    if (o_valid[d]) begin
      if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow dut%0d t=%0d: got valid word %0h want none", d, t, o_data[d]);
      end else begin
        if (d == 0) e = sb0.pop_front();
        else e = sb1.pop_front();
        chk("data", d, t, o_data[d], e);
        last[d] = e;
      end
    end else chk("hold", d, t, o_data[d], last[d]);
  endtask
  task automatic run_burst(input vec_t v, input int id);
    int span, n, cl;
    n = v.exp_words;
    span = n == 0 ? 12 : T_RCD + n + 3 + 2 + T_RP + 3;
    @(negedge sys_clk);
    init_end = v.init_end;
    rd_en = 1'b1;
    rd_addr = v.addr;
    rd_burst_len = 10'(v.len);
    rd_abort = 1'b0;
    for (int t = 0; t < span; t++) begin
      @(negedge sys_clk);
      for (int d = 0; d < 2; d++) check_cycle(d, t, v);
      if (n != 0) begin
        rd_en = 1'b0;
        rd_addr = 23'($urandom);
        rd_burst_len = 10'($urandom);
      end
      rd_abort = t == 0 || t == T_RCD + v.abort_k;
      rd_sdram_data = dq_of(t, id);
      for (int d = 0; d < 2; d++) begin
        cl = d == 0 ? 3 : 2;
        if (n != 0 && t >= T_RCD + cl && t < T_RCD + cl + n) begin
          if (d == 0) sb0.push_back(rd_sdram_data);
          else sb1.push_back(rd_sdram_data);
        end
      end
    end
    rd_en = 1'b0;
    rd_abort = 1'b0;
    init_end = 1'b1;
    chk("sb_left", 0, id, sb0.size(), 0);
    chk("sb_left", 1, id, sb1.size(), 0);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 8,   {2'd1, 12'h123, 9'h010}, -99, 8};
    tbl[1]  = '{1'b1, 1,   {2'd2, 12'h0ab, 9'h1f0}, -99, 1};
    tbl[2]  = '{1'b1, 600, {2'd3, 12'hfff, 9'h000}, -99, 512};
    tbl[3]  = '{1'b1, 16,  {2'd0, 12'h456, 9'h100}, 5,   6};
    tbl[4]  = '{1'b0, 8,   {2'd1, 12'h321, 9'h020}, -99, 0};
    tbl[5]  = '{1'b1, 0,   {2'd2, 12'h111, 9'h030}, -99, 0};
    tbl[6]  = '{1'b1, 4,   {2'd3, 12'h7a5, 9'h1ff}, 0,   4};
    tbl[7]  = '{1'b1, 5,   {2'd0, 12'h800, 9'h005}, 10,  5};
    tbl[8]  = '{1'b1, 3,   {2'd1, 12'h00f, 9'h0aa}, 1,   2};
    tbl[9]  = '{1'b1, 512, {2'd2, 12'hc3c, 9'h000}, -99, 512};
    tbl[10] = '{1'b1, 2,   {2'd3, 12'h5a5, 9'h155}, 1,   2};
    last[0] = '0;
    last[1] = '0;
    repeat (3) @(negedge sys_clk);
    check_reset("rst");
    sys_rst = 1'b0;
    for (int i = 0; i < 11; i++) run_burst(tbl[i], i);
    @(negedge sys_clk);
    rd_en = 1'b1;
    rd_addr = {2'd1, 12'h2aa, 9'h040};
    rd_burst_len = 10'd32;
    for (int t = 0; t <= T_RCD + 3; t++) begin
      @(negedge sys_clk);
      rd_en = 1'b0;
      rd_sdram_data = dq_of(t, 50);
      if (t == T_RCD + 3) sys_rst = 1'b1;
    end
    @(negedge sys_clk);
    check_reset("mid_rst");
    sys_rst = 1'b0;
    sb0.delete();
    sb1.delete();
    last[0] = '0;
    last[1] = '0;
    run_burst(tbl[0], 60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
